// File: rtl/pipe_pkg.sv
// pipe_pkg: occupancy encoding, per-stage widths and control-field bit offsets shared by pipeline stages.
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;
    localparam int EXMEM_DATA_W   = 96;
    localparam int EXMEM_CTRL_W   = 11;
    localparam int MEM_READ_BIT   = 0;
    localparam int MEM_WRITE_BIT  = 1;
    localparam int PC_SRC_BIT     = 2;
    localparam int MEM_TO_REG_BIT = 3;
    localparam int REG_WRITE_BIT  = 4;
    localparam int ZERO_BIT       = 5;
    localparam int RD_LSB         = 6;
    localparam int RD_W           = 5;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter with synchronous clear.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk)
        cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline-stage register with 2-entry skid buffer, registered in_ready and flush.
// PIPE_STAGE_BUF_PERF_EN adds a saturating output-stall cycle counter (perf_stall_cnt).
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = EXMEM_DATA_W,
    parameter int                CTRL_W   = EXMEM_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    output logic [15:0]       perf_stall_cnt
`endif
);
    occ_t              st, nxt;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              acc, emit;
    assign acc       = in_valid & in_ready & ~flush;
    assign out_valid = st != EMPTY;
    assign emit      = out_valid & out_ready;
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : CTRL_RST;
    assign occupancy = st;
    always_comb
        nxt = (st == EMPTY) ? (acc ? ONE : EMPTY) :
              (st == ONE)   ? ((acc && !emit) ? FULL : (!acc && emit) ? EMPTY : ONE) :
              (emit ? ONE : FULL);
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= EMPTY;
            in_ready  <= 1'b1;
            main_data <= '0;
            main_ctrl <= CTRL_RST;
            skid_data <= '0;
            skid_ctrl <= CTRL_RST;
        end else if (flush) begin
            st       <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            st       <= nxt;
            in_ready <= nxt != FULL;
            // in FULL acc is 0, so the skid entry is only ever drained here
            if (st == FULL && emit) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
                skid_data <= '0;
                skid_ctrl <= CTRL_RST;
            end else if (acc && (st == EMPTY || emit)) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (acc) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end
`ifdef PIPE_STAGE_BUF_PERF_EN
    pipe_sat_counter #(.W(16)) u_stall (
        .clk(clk),
        .clr(rst),
        .inc(out_valid & ~out_ready),
        .cnt(perf_stall_cnt)
    );
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed vector table plus queue-based scoreboard for pipe_stage_buf.
module tb_pipe_stage_buf;
    localparam int DW = 96;
    localparam int CW = 11;
    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;
    typedef struct {
        bit       iv;
        bit [7:0] t;
        bit       ordy;
        bit       fl;
        int       occ;
    } vec_t;
    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [15:0]   perf_stall_cnt;
`endif
    int            tests = 0;
    int            fails = 0;
    beat_t         q[$];
    vec_t          vecs[14];
    pipe_stage_buf dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_ctrl(in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_ctrl(out_ctrl),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_BUF_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // One clock: drive, check against the model mid-cycle, update the model, cross the edge.
    task automatic cycle(input bit iv, input bit [7:0] t, input bit ordy, input bit fl);
        beat_t b;
        bit    emit, acc;
        in_valid  = iv;
        in_data   = {12{t}};
        in_ctrl   = 11'h400 | 11'(t);
        out_ready = ordy;
        flush     = fl;
        #3;
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() != 2);
        chk("occupancy", occupancy, q.size());
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_ctrl", out_ctrl, q[0].c);
        end else
            chk("bubble_ctrl", out_ctrl, 0);
        emit = (q.size() != 0) && ordy;
        acc  = iv && (q.size() != 2) && !fl;
        if (emit) void'(q.pop_front());
        if (fl) q.delete();
        else if (acc) begin
            b.d = in_data;
            b.c = in_ctrl;
            q.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        vecs[0]  = '{1, 8'hA1, 0, 0, 1};
        vecs[1]  = '{1, 8'hB2, 0, 0, 2};
        vecs[2]  = '{1, 8'hC3, 0, 0, 2};
        vecs[3]  = '{1, 8'hC3, 1, 0, 1};
        vecs[4]  = '{1, 8'hC3, 1, 0, 1};
        vecs[5]  = '{0, 8'h00, 1, 0, 0};
        vecs[6]  = '{1, 8'hD1, 0, 0, 1};
        vecs[7]  = '{1, 8'hD2, 0, 0, 2};
        vecs[8]  = '{1, 8'hDD, 0, 1, 0};
        vecs[9]  = '{0, 8'h00, 1, 0, 0};
        vecs[10] = '{1, 8'hEE, 1, 1, 0};
        vecs[11] = '{1, 8'hF1, 1, 0, 1};
        vecs[12] = '{0, 8'h00, 1, 1, 0};
        vecs[13] = '{0, 8'h00, 0, 0, 0};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = '1; in_ctrl = 11'h7FF; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_data", out_data, 0);
`ifdef PIPE_STAGE_BUF_PERF_EN
        chk("rst_perf", perf_stall_cnt, 0);
`endif
        rst = 1'b0;
        q.delete();
        for (int i = 0; i < 8; i++) cycle(1, 8'(i), 1, 0);
        cycle(0, 0, 1, 0);
        foreach (vecs[i]) begin
            cycle(vecs[i].iv, vecs[i].t, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("vec%0d_occ", i), occupancy, vecs[i].occ);
        end
        for (int i = 0; i < 10000; i++)
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
`ifdef PIPE_STAGE_BUF_PERF_EN
        cycle(1, 8'h5A, 0, 0);
        in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("perf_sat", perf_stall_cnt, 16'hFFFF);
        cycle(0, 0, 0, 0);
        chk("perf_no_wrap", perf_stall_cnt, 16'hFFFF);
        cycle(0, 0, 1, 0);
`endif
        cycle(0, 0, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
